// File: rtl/stdp_pkg.sv
// rtl/stdp_pkg.sv - shared widths, types and STDP step table for stdp_ctrl
package stdp_pkg;

  localparam int W_WIDTH = 8;
  localparam int T_WIDTH = 4;
  localparam int A_MAX   = 16;
  localparam int T_WIN   = 8;

  typedef logic [W_WIDTH-1:0] weight_t;
  typedef logic [T_WIDTH-1:0] age_t;

  typedef enum logic [1:0] {
    UPD_NONE = 2'd0,
    UPD_LTP  = 2'd1,
    UPD_LTD  = 2'd2
  } upd_kind_t;

  // Halving step per cycle of spike separation; nothing outside 1..t_win.
  function automatic int unsigned stdp_step(input int unsigned dt,
                                            input int unsigned a_max,
                                            input int unsigned t_win);
    if (dt == 0 || dt > t_win) return 0;
    return a_max >> (dt - 1);
  endfunction

endpackage

// File: rtl/stdp_age_ctr.sv
// rtl/stdp_age_ctr.sv - cycles-since-spike counter, saturating at all-ones
module stdp_age_ctr #(
  parameter int T_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               spike,
  output logic [T_WIDTH-1:0] age
);

  localparam logic [T_WIDTH-1:0] AGE_SAT = '1;

  logic [T_WIDTH-1:0] age_q, age_d;

  always_comb begin
    age_d = age_q;
    if (spike)                age_d = T_WIDTH'(1);
    else if (age_q != AGE_SAT) age_d = age_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) age_q <= AGE_SAT;
    else        age_q <= age_d;
  end

  assign age = age_q;

endmodule

// File: rtl/stdp_ctrl.sv
// rtl/stdp_ctrl.sv - synaptic weight holder with pair-based STDP learning
module stdp_ctrl import stdp_pkg::*; #(
  parameter int W_WIDTH = stdp_pkg::W_WIDTH,
  parameter int T_WIDTH = stdp_pkg::T_WIDTH,
  parameter int W_INIT  = 16,
  parameter int W_MAX   = 255,
  parameter int W_MIN   = 0,
  parameter int A_MAX   = stdp_pkg::A_MAX,
  parameter int T_WIN   = stdp_pkg::T_WIN
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pre_spike,
  input  logic               post_spike,
  input  logic               learn_en,
  output logic [W_WIDTH-1:0] post_current,
  output logic [W_WIDTH-1:0] weight,
  output logic               upd_valid,
  output logic               upd_dir,
  output logic [T_WIDTH-1:0] dt_last
);

  localparam logic [W_WIDTH:0]   W_MAX_X  = W_MAX[W_WIDTH:0];
  localparam logic [W_WIDTH:0]   W_MIN_X  = W_MIN[W_WIDTH:0];
  localparam logic [W_WIDTH-1:0] W_INIT_W = W_INIT[W_WIDTH-1:0];
  localparam logic [T_WIDTH-1:0] T_WIN_A  = T_WIN[T_WIDTH-1:0];

  logic [T_WIDTH-1:0] pre_age, post_age;

  upd_kind_t          kind_q, kind_d;
  logic [T_WIDTH-1:0] pend_dt_q, pend_dt_d;
  logic [W_WIDTH-1:0] weight_q, weight_d;
  logic [W_WIDTH-1:0] post_current_q, post_current_d;
  logic               upd_valid_q, upd_valid_d;
  logic               upd_dir_q, upd_dir_d;
  logic [T_WIDTH-1:0] dt_last_q, dt_last_d;

  logic [W_WIDTH:0]   dw, sum, diff;

  stdp_age_ctr #(.T_WIDTH(T_WIDTH)) u_pre_age (
    .clk   (clk),
    .rst_n (rst_n),
    .spike (pre_spike),
    .age   (pre_age)
  );

  stdp_age_ctr #(.T_WIDTH(T_WIDTH)) u_post_age (
    .clk   (clk),
    .rst_n (rst_n),
    .spike (post_spike),
    .age   (post_age)
  );

  always_comb begin
    kind_d    = UPD_NONE;
    pend_dt_d = pend_dt_q;
    if (learn_en && post_spike && !pre_spike && pre_age <= T_WIN_A) begin
      kind_d    = UPD_LTP;
      pend_dt_d = pre_age;
    end else if (learn_en && pre_spike && !post_spike && post_age <= T_WIN_A) begin
      kind_d    = UPD_LTD;
      pend_dt_d = post_age;
    end
  end

  // Extra headroom bit so the clamps see true overflow/underflow.
  always_comb begin
    dw          = (W_WIDTH+1)'(stdp_step(32'(pend_dt_q), A_MAX, T_WIN));
    sum         = {1'b0, weight_q} + dw;
    diff        = {1'b0, weight_q} - dw;
    weight_d    = weight_q;
    upd_valid_d = 1'b0;
    upd_dir_d   = upd_dir_q;
    dt_last_d   = dt_last_q;
    case (kind_q)
      UPD_LTP: begin
        upd_valid_d = 1'b1;
        upd_dir_d   = 1'b1;
        dt_last_d   = pend_dt_q;
        weight_d    = (sum > W_MAX_X) ? W_MAX_X[W_WIDTH-1:0] : sum[W_WIDTH-1:0];
      end
      UPD_LTD: begin
        upd_valid_d = 1'b1;
        upd_dir_d   = 1'b0;
        dt_last_d   = pend_dt_q;
        weight_d    = (dw > {1'b0, weight_q} || diff < W_MIN_X) ? W_MIN_X[W_WIDTH-1:0]
                                                                : diff[W_WIDTH-1:0];
      end
      default: ;
    endcase
    post_current_d = pre_spike ? weight_q : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kind_q         <= UPD_NONE;
      pend_dt_q      <= '0;
      weight_q       <= W_INIT_W;
      post_current_q <= '0;
      upd_valid_q    <= 1'b0;
      upd_dir_q      <= 1'b0;
      dt_last_q      <= '0;
    end else begin
      kind_q         <= kind_d;
      pend_dt_q      <= pend_dt_d;
      weight_q       <= weight_d;
      post_current_q <= post_current_d;
      upd_valid_q    <= upd_valid_d;
      upd_dir_q      <= upd_dir_d;
      dt_last_q      <= dt_last_d;
    end
  end

  assign weight       = weight_q;
  assign post_current = post_current_q;
  assign upd_valid    = upd_valid_q;
  assign upd_dir      = upd_dir_q;
  assign dt_last      = dt_last_q;

endmodule
